video_timing_pattern_gen: RTL and testbench

//  Free-running raster timing generator with built-in test-pattern source. Produces hs/vs/de,

---
 rtl/video_timing_pattern_gen.sv | 146 ++++++++++++++
 tb/tb_video_timing_pattern_gen.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_pattern_gen.sv
// Free-running raster timing generator with a selectable built-in test pattern.
// Every output is registered from the same counter state, so they are mutually aligned.
module video_timing_pattern_gen #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  pattern_sel,
    input  logic [23:0] solid_color,
    output logic        o_hs,
    output logic        o_vs,
    output logic        o_de,
    output logic [11:0] o_x,
    output logic [11:0] o_y,
    output logic [23:0] o_data,
    output logic        o_frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_ACT_C  = 12'(H_ACTIVE);
    localparam logic [11:0] H_LAST_C = 12'(H_TOTAL - 1);
    localparam logic [11:0] HS_BEG_C = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END_C = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [11:0] V_ACT_C  = 12'(V_ACTIVE);
    localparam logic [11:0] V_LAST_C = 12'(V_TOTAL - 1);
    localparam logic [11:0] VS_BEG_C = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END_C = 12'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [11:0] BAR_LAST_C = 12'(H_ACTIVE / 8 - 1);

    function automatic logic [2:0] bar_sat_inc(input logic [2:0] b);
        return (b == 3'd7) ? b : b + 3'd1;
    endfunction

    function automatic logic [23:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return 24'hFFFFFF;
            3'd1:    return 24'hFFFF00;
            3'd2:    return 24'h00FFFF;
            3'd3:    return 24'h00FF00;
            3'd4:    return 24'hFF00FF;
            3'd5:    return 24'hFF0000;
            3'd6:    return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    logic [11:0] h_q, h_d, v_q, v_d, pix_q, pix_d;
    logic [2:0]  bar_q, bar_d;
    logic [1:0]  sel_q, sel_d;
    logic [23:0] solid_q, solid_d;
    logic        hs_d, vs_d, de_d, fs_d, act_h, act_v;
    logic [11:0] x_d, y_d;
    logic [23:0] pat, data_d;

    always_comb begin
        h_d     = (h_q == H_LAST_C) ? 12'd0 : h_q + 12'd1;
        v_d     = v_q;
        if (h_q == H_LAST_C) begin
            v_d = (v_q == V_LAST_C) ? 12'd0 : v_q + 12'd1;
        end

        // Pattern settings are latched at the top-left corner; the corner pixel itself
        // already uses the freshly sampled values.
        sel_d   = sel_q;
        solid_d = solid_q;
        if (h_q == 12'd0 && v_q == 12'd0) begin
            sel_d   = pattern_sel;
            solid_d = solid_color;
        end

        pix_d = pix_q;
        bar_d = bar_q;
        if (h_q == H_LAST_C) begin
            pix_d = 12'd0;
            bar_d = 3'd0;
        end else if (h_q < H_ACT_C) begin
            if (pix_q == BAR_LAST_C) begin
                pix_d = 12'd0;
                bar_d = bar_sat_inc(bar_q);
            end else begin
                pix_d = pix_q + 12'd1;
            end
        end

        act_h = (h_q < H_ACT_C);
        act_v = (v_q < V_ACT_C);
        de_d  = act_h && act_v;
        x_d   = act_h ? h_q : 12'd0;
        y_d   = act_v ? v_q : 12'd0;
        hs_d  = (h_q >= HS_BEG_C && h_q <= HS_END_C) ? HS_POL : ~HS_POL;
        vs_d  = (v_q >= VS_BEG_C && v_q <= VS_END_C) ? VS_POL : ~VS_POL;

        case (sel_d)
            2'd0:    pat = bar_color(bar_q);
            2'd1:    pat = (x_d[4:0] == 5'd0 || y_d[4:0] == 5'd0) ? 24'hFFFFFF : 24'h000000;
            2'd2:    pat = {x_d[7:0], y_d[7:0], 8'h80};
            default: pat = solid_d;
        endcase
        data_d = de_d ? pat : 24'h000000;
        fs_d   = de_d && (x_d == 12'd0) && (y_d == 12'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_q           <= 12'd0;
            v_q           <= 12'd0;
            pix_q         <= 12'd0;
            bar_q         <= 3'd0;
            sel_q         <= 2'd0;
            solid_q       <= 24'h000000;
            o_hs          <= ~HS_POL;
            o_vs          <= ~VS_POL;
            o_de          <= 1'b0;
            o_x           <= 12'd0;
            o_y           <= 12'd0;
            o_data        <= 24'h000000;
            o_frame_start <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            pix_q         <= pix_d;
            bar_q         <= bar_d;
            sel_q         <= sel_d;
            solid_q       <= solid_d;
            o_hs          <= hs_d;
            o_vs          <= vs_d;
            o_de          <= de_d;
            o_x           <= x_d;
            o_y           <= y_d;
            o_data        <= data_d;
            o_frame_start <= fs_d;
        end
    end

endmodule

// File: tb/tb_video_timing_pattern_gen.sv
// Bench for video_timing_pattern_gen on a small 24x8 raster: per-cycle reference model
// driven by frame position, plus a table of hand-computed pixel values.
module tb_video_timing_pattern_gen;

    localparam int HA = 16, HFP = 2, HSY = 3, HBP = 3;
    localparam int VA = 4, VFP = 1, VSY = 2, VBP = 1;
    localparam int HT = HA + HFP + HSY + HBP;
    localparam int VT = VA + VFP + VSY + VBP;
    localparam int FT = HT * VT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  pattern_sel = 2'd0;
    logic [23:0] solid_color = 24'h0;
    logic        o_hs, o_vs, o_de, o_frame_start;
    logic [11:0] o_x, o_y;
    logic [23:0] o_data;

    video_timing_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .pattern_sel(pattern_sel), .solid_color(solid_color),
        .o_hs(o_hs), .o_vs(o_vs), .o_de(o_de), .o_x(o_x), .o_y(o_y),
        .o_data(o_data), .o_frame_start(o_frame_start)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int p = 0;
    logic [1:0]  m_sel = 2'd0;
    logic [23:0] m_solid = 24'h0;

    typedef struct {
        logic [1:0]  sel;
        logic [23:0] solid;
        int          x;
        int          y;
        logic [23:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] model_pix(input int x, input int y,
                                              input logic [1:0] s, input logic [23:0] c);
        int b;
        case (s)
            2'd0: begin
                b = x / (HA / 8);
                if (b > 7) b = 7;
                case (b)
                    0: return 24'hFFFFFF;
                    1: return 24'hFFFF00;
                    2: return 24'h00FFFF;
                    3: return 24'h00FF00;
                    4: return 24'hFF00FF;
                    5: return 24'hFF0000;
                    6: return 24'h0000FF;
                    default: return 24'h000000;
                endcase
            end
            2'd1: return ((x % 32 == 0) || (y % 32 == 0)) ? 24'hFFFFFF : 24'h000000;
            2'd2: return {8'(x % 256), 8'(y % 256), 8'h80};
            default: return c;
        endcase
    endfunction

    // One clock: drive inputs, advance the model, compare every output.
    task automatic step(input logic r, input logic [1:0] s, input logic [23:0] c);
        logic e_hs, e_vs, e_de, e_fs;
        int h, v, ex, ey;
        logic [23:0] e_data;
        @(negedge clk);
        rst = r; pattern_sel = s; solid_color = c;
        @(posedge clk);
        if (r) begin
            e_hs = 1'b0; e_vs = 1'b0; e_de = 1'b0; e_fs = 1'b0;
            ex = 0; ey = 0; e_data = 24'h0;
            p = 0;
        end else begin
            h = p % HT;
            v = p / HT;
            if (p == 0) begin
                m_sel = s;
                m_solid = c;
            end
            e_de = (h < HA) && (v < VA);
            ex = (h < HA) ? h : 0;
            ey = (v < VA) ? v : 0;
            e_hs = (h >= HA + HFP) && (h < HA + HFP + HSY);
            e_vs = (v >= VA + VFP) && (v < VA + VFP + VSY);
            e_data = e_de ? model_pix(ex, ey, m_sel, m_solid) : 24'h0;
            e_fs = e_de && ex == 0 && ey == 0;
            p = (p + 1) % FT;
        end
        #1;
        check("hs", 32'(o_hs), 32'(e_hs));
        check("vs", 32'(o_vs), 32'(e_vs));
        check("de", 32'(o_de), 32'(e_de));
        check("x", 32'(o_x), 32'(ex));
        check("y", 32'(o_y), 32'(ey));
        check("data", 32'(o_data), 32'(e_data));
        check("frame_start", 32'(o_frame_start), 32'(e_fs));
    endtask

    initial begin
        vec_t vecs[$];
        int n_de, n_hs, n_vs, n_fs, n_sol, guard;
        bit found;

        vecs.push_back('{2'd0, 24'h0,  0, 0, 24'hFFFFFF});
        vecs.push_back('{2'd0, 24'h0,  1, 0, 24'hFFFFFF});
        vecs.push_back('{2'd0, 24'h0,  2, 1, 24'hFFFF00});
        vecs.push_back('{2'd0, 24'h0,  5, 2, 24'h00FFFF});
        vecs.push_back('{2'd0, 24'h0,  7, 0, 24'h00FF00});
        vecs.push_back('{2'd0, 24'h0,  9, 3, 24'hFF00FF});
        vecs.push_back('{2'd0, 24'h0, 10, 0, 24'hFF0000});
        vecs.push_back('{2'd0, 24'h0, 13, 1, 24'h0000FF});
        vecs.push_back('{2'd0, 24'h0, 15, 3, 24'h000000});
        vecs.push_back('{2'd2, 24'h0,  5, 3, 24'h050380});
        vecs.push_back('{2'd1, 24'h0,  0, 2, 24'hFFFFFF});
        vecs.push_back('{2'd1, 24'h0,  1, 1, 24'h000000});
        vecs.push_back('{2'd1, 24'h0,  3, 0, 24'hFFFFFF});
        vecs.push_back('{2'd3, 24'h123456, 4, 2, 24'h123456});

        // Reset held for a few cycles.
        for (int i = 0; i < 3; i++) step(1'b1, 2'd0, 24'h0);

        // First cycle after release, then one whole frame of statistics.
        step(1'b0, 2'd0, 24'h0);
        check("rel_de", 32'(o_de), 32'd1);
        check("rel_x", 32'(o_x), 32'd0);
        check("rel_y", 32'(o_y), 32'd0);
        check("rel_fs", 32'(o_frame_start), 32'd1);
        n_de = int'(o_de); n_hs = int'(o_hs); n_vs = int'(o_vs); n_fs = int'(o_frame_start);
        for (int i = 1; i < FT; i++) begin
            step(1'b0, 2'd0, 24'h0);
            n_de += int'(o_de); n_hs += int'(o_hs);
            n_vs += int'(o_vs); n_fs += int'(o_frame_start);
        end
        check("frame_de_count", 32'(n_de), 32'd64);
        check("frame_hs_count", 32'(n_hs), 32'd24);
        check("frame_vs_count", 32'(n_vs), 32'd48);
        check("frame_fs_count", 32'(n_fs), 32'd1);
        step(1'b0, 2'd0, 24'h0);
        check("period_fs", 32'(o_frame_start), 32'd1);

        // Random frames with random pattern selections.
        for (int f = 0; f < 3; f++) begin
            logic [1:0]  rs;
            logic [23:0] rc;
            rs = 2'($urandom_range(0, 3));
            rc = 24'($urandom);
            for (int i = 0; i < FT; i++) begin
                if ($urandom_range(0, 15) == 0) begin
                    rs = 2'($urandom_range(0, 3));
                    rc = 24'($urandom);
                end
                step(1'b0, rs, rc);
            end
        end

        // Table of hand-computed pixels.
        foreach (vecs[i]) begin
            found = 1'b0;
            guard = 0;
            while (!found && guard < 3 * FT) begin
                step(1'b0, vecs[i].sel, vecs[i].solid);
                guard++;
                if (m_sel == vecs[i].sel && m_solid == vecs[i].solid && o_de &&
                    int'(o_x) == vecs[i].x && int'(o_y) == vecs[i].y) found = 1'b1;
            end
            check($sformatf("vec%0d_reached", i), 32'(found), 32'd1);
            if (found) check($sformatf("vec%0d_data", i), 32'(o_data), 32'(vecs[i].exp));
        end

        // Pattern change at the frame midpoint applies only from the next frame.
        guard = 0;
        while (p != 0 && guard < 2 * FT) begin step(1'b0, 2'd0, 24'h0); guard++; end
        for (int i = 0; i < FT / 2; i++) step(1'b0, 2'd0, 24'h0);
        n_sol = 0;
        guard = 0;
        while (p != 0 && guard < 2 * FT) begin
            step(1'b0, 2'd3, 24'h123456);
            guard++;
            if (o_de && o_data == 24'h123456) n_sol++;
        end
        check("mid_switch_old_frame", 32'(n_sol), 32'd0);
        n_sol = 0;
        for (int i = 0; i < FT; i++) begin
            step(1'b0, 2'd3, 24'h123456);
            if (o_de && o_data == 24'h123456) n_sol++;
        end
        check("mid_switch_new_frame", 32'(n_sol), 32'd64);

        // Reset pulse while the next sampled pixel is x=7,y=2.
        guard = 0;
        while (p != 2 * HT + 7 && guard < 2 * FT) begin step(1'b0, 2'd0, 24'h0); guard++; end
        check("rst_pos_reached", 32'(p), 32'(2 * HT + 7));
        step(1'b1, 2'd0, 24'h0);
        check("midrst_de", 32'(o_de), 32'd0);
        check("midrst_x", 32'(o_x), 32'd0);
        check("midrst_data", 32'(o_data), 32'd0);
        check("midrst_hs", 32'(o_hs), 32'd0);
        step(1'b0, 2'd0, 24'h0);
        check("after_rst_fs", 32'(o_frame_start), 32'd1);
        check("after_rst_x", 32'(o_x), 32'd0);
        check("after_rst_y", 32'(o_y), 32'd0);
        check("after_rst_data", 32'(o_data), 32'hFFFFFF);
        for (int i = 0; i < HT * 2; i++) step(1'b0, 2'd0, 24'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
